conv_frame_ctrl: RTL and testbench
==================================

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  frame start request; sampled only in IDLE.
REQ-005 frame_len  input  8  frame length in bytes, sampled with accepted start; 0 means 256.
REQ-006 in_data  input  8  payload byte, serialized MSB first.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  controller accepts a byte this cycle.
REQ-009 out_sym  output  2  encoded symbol {G1 bit, G0 bit}.
REQ-010 out_valid  output  1  out_sym valid.
REQ-011 out_ready  input  1  downstream accepts out_sym.
REQ-012 out_last  output  1  qualifies the final symbol of a frame.
REQ-013 busy  output  1  high from accepted start until done pulse.
REQ-014 done  output  1  one-cycle pulse after the final symbol is accepted.

Function
REQ-015 SHALL contain a 3-bit encoder shift register sr = {u(n-2), u(n-1), u(n)}, cleared on accepted start.
REQ-016 For each input bit u(n): out_sym[0] = u(n) ^ u(n-2), out_sym[1] = u(n-1) ^ u(n-2), evaluated after u(n) enters sr.
REQ-017 States: IDLE, LOAD, SHIFT, TAIL, DONE.
REQ-018 IDLE: start=1 -> LOAD; latch frame_len into a 9-bit byte counter; clear sr; busy=1 from the next cycle.
REQ-019 LOAD: in_ready=1; on in_valid&in_ready, latch the byte, decrement the byte counter -> SHIFT.
REQ-020 SHIFT: emits 8 symbols for bits 7..0; a bit advances only on the cycle its symbol handshake (out_valid&out_ready) completes.
REQ-021 After bit 0 is accepted: byte counter nonzero -> LOAD, else -> TAIL.
REQ-022 TAIL: feeds two zero bits, emitting 2 symbols; out_last=1 on the second; after its handshake -> DONE.
REQ-023 DONE: done=1 and busy=0 for one cycle -> IDLE.
REQ-024 Symbols per frame SHALL be exactly 8*L+2, where L = frame_len (256 when 0).
REQ-025 out_sym and out_last SHALL be registered; the first symbol of a byte is valid the cycle after the byte handshake.
REQ-026 While out_valid=1 and out_ready=0, out_sym, out_last and out_valid SHALL hold stable.
REQ-027 in_ready SHALL be 0 in all states except LOAD; one idle bubble per byte is permitted.
REQ-028 start outside IDLE SHALL be ignored; frame_len changes after acceptance SHALL have no effect.
REQ-029 in_valid outside LOAD SHALL be ignored, with no byte consumed.
REQ-030 out_ready=1 with out_valid=0 SHALL have no effect.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, sr=0, counter=0, out_sym=0, out_valid=0, out_last=0, in_ready=0, busy=0, done=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no done pulse; the first start after deassertion begins a clean frame.

Verification
REQ-033 L=1, byte 0x80, out_ready=1 -> out_sym sequence 1,2,3,0,0,0,0,0,0,0; out_last on the 10th; done one cycle later.
REQ-034 L=1, byte 0x01 -> 0,0,0,0,0,0,0,1,2,3 (tail flush visible); out_last on symbol 3.
REQ-035 L=2, bytes 0xFF,0x00, out_ready toggling 1/0 each cycle -> 18 symbols, each held stable while stalled; in_ready high exactly twice.
REQ-036 frame_len=0 -> 256 byte handshakes and 2050 symbols before done; start pulses while busy are ignored.
REQ-037 rst_n asserted after 5 symbols of an L=4 frame -> all outputs 0 asynchronously; a new L=1 frame with 0x80 then yields REQ-033's sequence.

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// Frame controller for a rate-1/2, K=3 convolutional encoder (G0=101, G1=011).
// Serializes bytes MSB first, emits one 2-bit symbol per bit, then a 2-bit zero tail.
module conv_frame_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] out_sym,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StTail, StDone} state_e;

  state_e     r_state,     w_state;
  logic [8:0] r_cnt,       w_cnt;
  logic [2:0] r_sr,        w_sr;
  logic [7:0] r_byte,      w_byte;
  logic [2:0] r_bit_idx,   w_bit_idx;
  logic       r_tail,      w_tail;
  logic [1:0] r_out_sym,   w_out_sym;
  logic       r_out_valid, w_out_valid;
  logic       r_out_last,  w_out_last;

  logic       w_adv;
  logic       w_bit;
  logic [2:0] w_sr_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 9'd0;
      r_sr        <= 3'd0;
      r_byte      <= 8'd0;
      r_bit_idx   <= 3'd0;
      r_tail      <= 1'b0;
      r_out_sym   <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_sr        <= w_sr;
      r_byte      <= w_byte;
      r_bit_idx   <= w_bit_idx;
      r_tail      <= w_tail;
      r_out_sym   <= w_out_sym;
      r_out_valid <= w_out_valid;
      r_out_last  <= w_out_last;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_sr        = r_sr;
    w_byte      = r_byte;
    w_bit_idx   = r_bit_idx;
    w_tail      = r_tail;
    w_out_sym   = r_out_sym;
    w_out_valid = r_out_valid;
    w_out_last  = r_out_last;
    w_adv       = 1'b0;
    w_bit       = 1'b0;
    w_sr_shift  = 3'd0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state = StLoad;
          w_cnt   = (frame_len == 8'd0) ? 9'd256 : {1'b0, frame_len};
          w_sr    = 3'd0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          w_byte      = in_data;
          w_cnt       = r_cnt - 9'd1;
          w_bit_idx   = 3'd7;
          w_bit       = in_data[7];
          w_adv       = 1'b1;
          w_out_valid = 1'b1;
          w_out_last  = 1'b0;
          w_state     = StShift;
        end
      end
      StShift: begin
        if (out_ready) begin
          if (r_bit_idx != 3'd0) begin
            w_bit_idx = r_bit_idx - 3'd1;
            w_bit     = r_byte[r_bit_idx - 3'd1];
            w_adv     = 1'b1;
          end else if (r_cnt != 9'd0) begin
            w_out_valid = 1'b0;
            w_state     = StLoad;
          end else begin
            // First flush bit follows bit 0 of the last byte with no bubble.
            w_adv   = 1'b1;
            w_tail  = 1'b0;
            w_state = StTail;
          end
        end
      end
      StTail: begin
        if (out_ready) begin
          if (!r_tail) begin
            w_adv      = 1'b1;
            w_tail     = 1'b1;
            w_out_last = 1'b1;
          end else begin
            w_out_valid = 1'b0;
            w_out_last  = 1'b0;
            w_state     = StDone;
          end
        end
      end
      StDone: begin
        w_state = StIdle;
      end
      default: begin
        w_state = StIdle;
      end
    endcase

    // Symbol is encoded from the register contents after the new bit enters.
    if (w_adv) begin
      w_sr_shift = {r_sr[1:0], w_bit};
      w_sr       = w_sr_shift;
      w_out_sym  = {w_sr_shift[1] ^ w_sr_shift[2], w_sr_shift[0] ^ w_sr_shift[2]};
    end
  end

  assign in_ready  = (r_state == StLoad);
  assign busy      = (r_state == StLoad) || (r_state == StShift) || (r_state == StTail);
  assign done      = (r_state == StDone);
  assign out_sym   = r_out_sym;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl: directed frames, stalls, long frame and mid-frame reset.
module tb_conv_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] frame_len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_sym;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  conv_frame_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sym   (out_sym),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [2:0] sb[$];      // expected {last, sym}
  logic [7:0] byte_q[$];  // bytes still to be offered
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_cyc = -10;
  int sym_cnt  = 0;
  int done_cnt = 0;
  int ir_cnt   = 0;
  int byte_hs  = 0;
  bit hs_in    = 1'b0;
  bit rdy_mode = 1'b0;
  bit stall_pending = 1'b0;
  logic [2:0] stall_val;

  int e33[10] = '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0};
  int e34[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
  int e35[18] = '{1, 3, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  task automatic push_exp(input int sym, input bit last);
    sb.push_back({last, sym[1:0]});
  endtask

  // Reference encoder over the whole bit stream including the zero tail.
  task automatic push_model(input logic [7:0] bytes[$]);
    bit u[$];
    int b, c;
    foreach (bytes[i]) for (int k = 7; k >= 0; k--) u.push_back(bytes[i][k]);
    u.push_back(1'b0);
    u.push_back(1'b0);
    for (int n = 0; n < u.size(); n++) begin
      b = (n >= 1) ? int'(u[n-1]) : 0;
      c = (n >= 2) ? int'(u[n-2]) : 0;
      push_exp(((b ^ c) << 1) | (int'(u[n]) ^ c), n == u.size() - 1);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      stall_pending = 1'b0;
      hs_in = 1'b0;
    end else begin
      if (in_ready) ir_cnt++;
      hs_in = in_valid && in_ready;
      if (hs_in) byte_hs++;
      if (stall_pending) chk("stall_hold", {out_valid, out_last, out_sym}, {1'b1, stall_val});
      stall_pending = out_valid && !out_ready;
      stall_val = {out_last, out_sym};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_symbol", {out_last, out_sym}, -1);
        else chk("symbol", {out_last, out_sym}, sb.pop_front());
        sym_cnt++;
        if (out_last) last_cyc = cyc;
      end
      if (done) begin
        chk("done_timing", cyc, last_cyc + 1);
        chk("busy_at_done", busy, 0);
        done_cnt++;
      end
    end
  end

  // Input driver: updates inputs 1 time unit after each rising edge.
  initial begin
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hs_in && byte_q.size() > 0) void'(byte_q.pop_front());
      hs_in    = 1'b0;
      in_valid = (byte_q.size() > 0);
      in_data  = in_valid ? byte_q[0] : 8'd0;
      out_ready = rdy_mode ? ~out_ready : 1'b1;
    end
  end

  task automatic do_start(input logic [7:0] len);
    @(posedge clk);
    #1;
    start = 1'b1;
    frame_len = len;
    @(posedge clk);
    #1;
    start = 1'b0;
    frame_len = ~len;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int limit, input string name);
    int d0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == d0; i++) @(negedge clk);
    chk({name, "_done_seen"}, done_cnt, d0 + 1);
    chk({name, "_sb_empty"}, sb.size(), 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, {done, busy}, 0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_sym"},   out_sym, 0);
    chk({name, "_out_last"},  out_last, 0);
    chk({name, "_in_ready"},  in_ready, 0);
    chk({name, "_busy"},      busy, 0);
    chk({name, "_done"},      done, 0);
  endtask

  initial begin
    logic [7:0] bq[$];
    int s0, d0;
    rst_n = 1'b0;
    start = 1'b0;
    frame_len = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single byte 0x80.
    byte_q.push_back(8'h80);
    foreach (e33[i]) push_exp(e33[i], i == 9);
    do_start(8'd1);
    wait_done(100, "l1_80");

    // Single byte 0x01: tail flush visible.
    byte_q.push_back(8'h01);
    foreach (e34[i]) push_exp(e34[i], i == 9);
    do_start(8'd1);
    wait_done(100, "l1_01");

    // Two bytes with downstream stalling every other cycle.
    rdy_mode = 1'b1;
    ir_cnt = 0;
    s0 = sym_cnt;
    byte_q.push_back(8'hFF);
    byte_q.push_back(8'h00);
    foreach (e35[i]) push_exp(e35[i], i == 17);
    do_start(8'd2);
    wait_done(200, "l2_stall");
    chk("l2_in_ready_cycles", ir_cnt, 2);
    chk("l2_symbols", sym_cnt - s0, 18);
    rdy_mode = 1'b0;

    // 256-byte frame; extra start pulses while busy must be ignored.
    bq.delete();
    for (int i = 0; i < 256; i++) bq.push_back(8'(i * 37 + 5));
    byte_q = bq;
    push_model(bq);
    s0 = sym_cnt;
    byte_hs = 0;
    do_start(8'd0);
    repeat (300) @(posedge clk);
    #1;
    start = 1'b1;
    frame_len = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5000, "l256");
    chk("l256_byte_hs", byte_hs, 256);
    chk("l256_symbols", sym_cnt - s0, 2050);

    // Reset after 5 symbols of a 4-byte frame.
    bq.delete();
    bq.push_back(8'hA5);
    bq.push_back(8'h3C);
    bq.push_back(8'h0F);
    bq.push_back(8'hF0);
    byte_q = bq;
    push_model(bq);
    s0 = sym_cnt;
    d0 = done_cnt;
    do_start(8'd4);
    for (int i = 0; i < 100 && sym_cnt < s0 + 5; i++) @(negedge clk);
    chk("rst_five_symbols", sym_cnt - s0, 5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    byte_q.delete();
    #1;
    check_idle_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_abort", done_cnt, d0);

    byte_q.push_back(8'h80);
    foreach (e33[i]) push_exp(e33[i], i == 9);
    do_start(8'd1);
    wait_done(100, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
